fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Program-counter and fetch sequencer for the 8-bit-instruction core; the initiator side of the combinational instruction ROM. It drives `pc`, consumes the decoded `opcode` and `jmp_loc` returned for that `pc`, resolves jumps and branches against ALU compare flags, and stalls on load/store handshakes. It issues the per-instruction commit strobe to the register file and ALU, stops on HALT, and counts retired instructions.

## Interface
- `START_PC`, default 16'd0: PC loaded on `start`.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high; sampled on `clk` rising edge.
- `start`  in  1  begin execution; honoured in IDLE and HALTED only.
- `opcode`  in  4  decoded opcode for the current `pc` (combinational from ROM).
- `jmp_loc`  in  16  jump/branch target for the current `pc`; may be X for non-control opcodes.
- `cond_eq`  in  1  ALU: reg1 == reg2 for the current instruction.
- `cond_lt`  in  1  ALU: reg1 < reg2, unsigned.
- `mem_ack`  in  1  data memory completion for the outstanding request.
- `pc`  out  16  current instruction address.
- `commit`  out  1  current instruction retires this cycle; writes enabled.
- `mem_req`  out  1  data memory request for LB/LHB/STR.
- `halted`  out  1  HALT has retired.
- `instr_count`  out  16  retired-instruction count, saturating.

## Operation
- States: IDLE, RUN, MEM_WAIT, HALTED.
- Reset values: state IDLE, `pc` = 0, `instr_count` = 0, `commit` = 0, `mem_req` = 0, `halted` = 0.
- IDLE: if `start` = 1, then `pc` <= START_PC, `instr_count` <= 0, and the state moves to RUN.
- RUN, opcodes other than LB/LHB/STR/HALT: `commit` = 1, `instr_count` increments, `pc` <= next_pc, and the state stays in RUN.
- next_pc is:
  - JMP: `jmp_loc`.
  - BNE: `jmp_loc` if !`cond_eq`.
  - BEQ: `jmp_loc` if `cond_eq`.
  - BLT: `jmp_loc` if `cond_lt`.
  - Otherwise, including untaken branches and TBA (treated as NOP): `pc` + 1, wrapping 16'hFFFF -> 16'h0000.
- RUN, LB/LHB/STR: `mem_req` = 1, no commit, and the state moves to MEM_WAIT.
- MEM_WAIT: `mem_req` = 1. On `mem_ack` = 1: `commit` = 1, count increments, `pc` <= `pc` + 1, state RUN. Otherwise it holds. There is no timeout.
- RUN, HALT: `commit` = 1, count increments, `pc` is held, and the state moves to HALTED.
- HALTED: `halted` = 1.
  - `start` restarts exactly as from IDLE; `halted` drops the next cycle.
- `start` in RUN/MEM_WAIT is ignored.
- `mem_ack` outside MEM_WAIT is ignored.
- `instr_count` saturates at 16'hFFFF.
- Reset in any state, including mid MEM_WAIT, returns to reset values on that edge. `mem_req` is low in the following cycle.
- `cond_eq`/`cond_lt` are sampled only in RUN on branch opcodes.

## Timing
- `commit`, `mem_req` and `halted` are combinational from state and `opcode`. `pc` and `instr_count` are registered.
- Single-cycle instructions: one instruction per clock in RUN. The first `commit` occurs the cycle after `start` is sampled.
- Taken jump/branch: the target is fetched on the next cycle. There is no delay slot and no bubble.
- Memory op: minimum 2 cycles (RUN + MEM_WAIT with ack). Each further ack-free cycle adds one.
- HALT: `halted` is asserted the cycle after HALT commits.

## Structure
- Shared package `isa_pkg`:
  - 4-bit opcode enum (LB, LHB, JMP, STR, LIM, MVB, MVF, ADD, SUB, SFT, BNE, BEQ, BLT, INC, HALT, TBA).
  - 2-bit format enum (C, I, M, X).
  - `is_mem_op` and `is_branch_op` helper functions.
  - The ROM decoder migrates to the same package.
- Sub-module `next_pc_logic`: combinational next_pc from `opcode`, `pc`, `jmp_loc`, `cond_eq` and `cond_lt`. The FSM, counter and handshake stay in `fetch_sequencer`.

## Test plan
- Reset then `start` with START_PC = 0 and all opcodes ADD -> `pc` reads 0, 1, 2, 3 on successive cycles, `commit` is high each cycle, and `instr_count` = 3 after 3 commits.
- At `pc` = 5, JMP with `jmp_loc` = 10 -> next `pc` = 10. BEQ at 10 with `cond_eq` = 0 -> `pc` = 11. BLT at 11 with `cond_lt` = 1 and `jmp_loc` = 2 -> `pc` = 2.
- STR at `pc` = 7 with `mem_ack` raised on the 3rd MEM_WAIT cycle -> `mem_req` is high for 4 cycles, there is one `commit`, and `pc` = 8 afterwards.
- HALT at `pc` = 30 -> `commit` for one cycle, then `halted` = 1 and `pc` stays 30. Pulsing `start` -> `pc` = START_PC and `instr_count` = 0.
- `pc` = 16'hFFFF running ADD -> next `pc` = 0. Preloading `instr_count` to 16'hFFFF via a long run -> the count stays 16'hFFFF.
- Reset asserted in MEM_WAIT with `mem_ack` = 1 in the same cycle -> no commit, then state IDLE, `pc` = 0 and `mem_req` = 0 next cycle.

Source files
------------

// File: rtl/isa_pkg.sv
// ---------------------------------------------------------------------------
// isa_pkg : opcode/format encodings, opcode class helpers, ROM word decoder
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package isa_pkg;

  localparam int c_PC_W = 16;

  typedef enum logic [3:0] {
    OP_LB   = 4'd0,
    OP_LHB  = 4'd1,
    OP_JMP  = 4'd2,
    OP_STR  = 4'd3,
    OP_LIM  = 4'd4,
    OP_MVB  = 4'd5,
    OP_MVF  = 4'd6,
    OP_ADD  = 4'd7,
    OP_SUB  = 4'd8,
    OP_SFT  = 4'd9,
    OP_BNE  = 4'd10,
    OP_BEQ  = 4'd11,
    OP_BLT  = 4'd12,
    OP_INC  = 4'd13,
    OP_HALT = 4'd14,
    OP_TBA  = 4'd15
  } opcode_e;

  typedef enum logic [1:0] {
    FMT_C = 2'd0,
    FMT_I = 2'd1,
    FMT_M = 2'd2,
    FMT_X = 2'd3
  } format_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_HALTED   = 2'd3
  } seq_state_e;

  function automatic logic is_mem_op(input opcode_e op);
    return (op == OP_LB) || (op == OP_LHB) || (op == OP_STR);
  endfunction

  function automatic logic is_branch_op(input opcode_e op);
    return (op == OP_BNE) || (op == OP_BEQ) || (op == OP_BLT);
  endfunction

  // ROM words carry the opcode in the upper nibble
  function automatic opcode_e rom_decode_opcode(input logic [7:0] instr);
    return opcode_e'(instr[7:4]);
  endfunction

  function automatic format_e rom_decode_format(input opcode_e op);
    format_e fmt;
    case (op)
      OP_LB, OP_LHB, OP_STR:                       fmt = FMT_M;
      OP_JMP, OP_BNE, OP_BEQ, OP_BLT, OP_HALT, OP_TBA: fmt = FMT_C;
      OP_LIM:                                      fmt = FMT_I;
      default:                                     fmt = FMT_X;
    endcase
    return fmt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/next_pc_logic.sv
// ---------------------------------------------------------------------------
// next_pc_logic : combinational next-PC selection for jumps and branches
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module next_pc_logic
  import isa_pkg::*;
(
  input  logic [3:0]  i_opcode,
  input  logic [15:0] i_pc,
  input  logic [15:0] i_jmp_loc,
  input  logic        i_cond_eq,
  input  logic        i_cond_lt,
  output logic [15:0] o_next_pc
);

  opcode_e w_op;
  logic    w_taken;

  assign w_op = opcode_e'(i_opcode);

  always_comb begin
    w_taken = 1'b0;
    case (w_op)
      OP_JMP:  w_taken = 1'b1;
      OP_BNE:  w_taken = ~i_cond_eq;
      OP_BEQ:  w_taken = i_cond_eq;
      OP_BLT:  w_taken = i_cond_lt;
      default: w_taken = 1'b0;
    endcase
  end

  // jmp_loc may be X on sequential opcodes; it is only selected when taken
  assign o_next_pc = w_taken ? i_jmp_loc : (i_pc + 16'd1);

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer : PC/fetch FSM with memory stall, HALT and retire counter
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_sequencer
  import isa_pkg::*;
#(
  parameter logic [15:0] START_PC = 16'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  opcode,
  input  logic [15:0] jmp_loc,
  input  logic        cond_eq,
  input  logic        cond_lt,
  input  logic        mem_ack,
  output logic [15:0] pc,
  output logic        commit,
  output logic        mem_req,
  output logic        halted,
  output logic [15:0] instr_count
);

  seq_state_e  r_state;
  seq_state_e  w_state_nxt;
  logic [15:0] r_pc;
  logic [15:0] w_pc_nxt;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic [15:0] w_branch_pc;
  logic        w_commit;
  logic        w_mem_req;
  logic        w_halted;
  opcode_e     w_op;

  assign w_op = opcode_e'(opcode);

  next_pc_logic u_next_pc (
    .i_opcode  (opcode),
    .i_pc      (r_pc),
    .i_jmp_loc (jmp_loc),
    .i_cond_eq (cond_eq),
    .i_cond_lt (cond_lt),
    .o_next_pc (w_branch_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_pc    <= 16'd0;
      r_cnt   <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    w_mem_req   = 1'b0;
    w_halted    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_pc_nxt    = START_PC;
        end
      end
      ST_RUN: begin
        if (is_mem_op(w_op)) begin
          w_mem_req   = 1'b1;
          w_state_nxt = ST_MEM_WAIT;
        end else if (w_op == OP_HALT) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_HALTED;
        end else begin
          w_commit = 1'b1;
          w_pc_nxt = w_branch_pc;
        end
      end
      ST_MEM_WAIT: begin
        w_mem_req = 1'b1;
        if (mem_ack) begin
          w_commit    = 1'b1;
          w_pc_nxt    = r_pc + 16'd1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_HALTED: begin
        w_halted = 1'b1;
        if (start) begin
          w_state_nxt = ST_RUN;
          w_pc_nxt    = START_PC;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // A restart clears the count; otherwise retirements bump it up to saturation
    if (w_state_nxt == ST_RUN && (r_state == ST_IDLE || r_state == ST_HALTED)) begin
      w_cnt_nxt = 16'd0;
    end else if (w_commit && (r_cnt != 16'hFFFF)) begin
      w_cnt_nxt = r_cnt + 16'd1;
    end
  end

  // Reset kills a same-cycle retirement so no register write escapes
  assign commit      = w_commit & ~reset;
  assign mem_req     = w_mem_req;
  assign halted      = w_halted;
  assign pc          = r_pc;
  assign instr_count = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer : directed vectors with queued expectations for fetch_sequencer
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fetch_sequencer;
  import isa_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  opcode;
  logic [15:0] jmp_loc;
  logic        cond_eq;
  logic        cond_lt;
  logic        mem_ack;
  logic [15:0] pc;
  logic        commit;
  logic        mem_req;
  logic        halted;
  logic [15:0] instr_count;

  typedef struct {
    logic [15:0] pc;
    logic        commit;
    logic        mem_req;
    logic        halted;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  fetch_sequencer #(.START_PC(16'd0)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .opcode      (opcode),
    .jmp_loc     (jmp_loc),
    .cond_eq     (cond_eq),
    .cond_lt     (cond_lt),
    .mem_ack     (mem_ack),
    .pc          (pc),
    .commit      (commit),
    .mem_req     (mem_req),
    .halted      (halted),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

  // Drive one cycle of inputs at the falling edge; optionally queue what the DUT must show
  task automatic step(input logic [3:0] op, input logic [15:0] jl, input logic eq,
                      input logic lt, input logic ack, input logic st, input logic rs,
                      input logic chk, input logic [15:0] epc, input logic ec,
                      input logic em, input logic eh, input logic [15:0] ecnt);
    exp_t e;
    @(negedge clk);
    opcode  = op;
    jmp_loc = jl;
    cond_eq = eq;
    cond_lt = lt;
    mem_ack = ack;
    start   = st;
    reset   = rs;
    if (chk) begin
      e.pc = epc; e.commit = ec; e.mem_req = em; e.halted = eh; e.cnt = ecnt;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: samples mid low-phase, well away from the rising edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (pc !== e.pc) begin
          miscompares++;
          $display("FAIL pc vec%0d: got %h expected %h", vectors, pc, e.pc);
        end
        if (commit !== e.commit) begin
          miscompares++;
          $display("FAIL commit vec%0d: got %b expected %b", vectors, commit, e.commit);
        end
        if (mem_req !== e.mem_req) begin
          miscompares++;
          $display("FAIL mem_req vec%0d: got %b expected %b", vectors, mem_req, e.mem_req);
        end
        if (halted !== e.halted) begin
          miscompares++;
          $display("FAIL halted vec%0d: got %b expected %b", vectors, halted, e.halted);
        end
        if (instr_count !== e.cnt) begin
          miscompares++;
          $display("FAIL instr_count vec%0d: got %h expected %h", vectors, instr_count, e.cnt);
        end
      end
    end
  end

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1; start = 1'b0; opcode = OP_ADD; jmp_loc = 16'd0;
    cond_eq = 1'b0; cond_lt = 1'b0; mem_ack = 1'b0;

    // args: op, jmp_loc, eq, lt, ack, start, reset, chk, pc, commit, mem_req, halted, count
    step(OP_ADD,  16'd0,  0,0,0,0,1, 0, 16'd0,  0,0,0, 16'd0);
    step(OP_ADD,  16'd0,  0,0,0,0,1, 0, 16'd0,  0,0,0, 16'd0);
    step(OP_ADD,  16'd0,  0,0,0,0,0, 1, 16'd0,  0,0,0, 16'd0);   // reset state, IDLE
    step(OP_ADD,  16'd0,  0,0,0,1,0, 1, 16'd0,  0,0,0, 16'd0);   // start sampled
    step(OP_ADD,  16'd0,  0,0,0,0,0, 1, 16'd0,  1,0,0, 16'd0);
    step(OP_ADD,  16'd0,  0,0,0,0,0, 1, 16'd1,  1,0,0, 16'd1);
    step(OP_ADD,  16'd0,  0,0,0,0,0, 1, 16'd2,  1,0,0, 16'd2);
    step(OP_ADD,  16'd0,  0,0,0,0,0, 1, 16'd3,  1,0,0, 16'd3);
    step(OP_ADD,  16'd0,  0,0,0,0,0, 1, 16'd4,  1,0,0, 16'd4);
    step(OP_JMP,  16'd10, 0,0,0,0,0, 1, 16'd5,  1,0,0, 16'd5);
    step(OP_BEQ,  16'd3,  0,1,0,0,0, 1, 16'd10, 1,0,0, 16'd6);   // not taken
    step(OP_BLT,  16'd2,  0,1,0,0,0, 1, 16'd11, 1,0,0, 16'd7);   // taken
    step(OP_ADD,  16'd0,  0,0,0,0,0, 1, 16'd2,  1,0,0, 16'd8);
    step(OP_ADD,  16'd0,  0,0,0,0,0, 1, 16'd3,  1,0,0, 16'd9);
    step(OP_ADD,  16'd0,  0,0,0,0,0, 1, 16'd4,  1,0,0, 16'd10);
    step(OP_ADD,  16'd0,  0,0,0,0,0, 1, 16'd5,  1,0,0, 16'd11);
    step(OP_ADD,  16'd0,  0,0,0,0,0, 1, 16'd6,  1,0,0, 16'd12);
    step(OP_STR,  16'd0,  0,0,0,0,0, 1, 16'd7,  0,1,0, 16'd13);  // RUN half of STR
    step(OP_STR,  16'd0,  0,0,0,0,0, 1, 16'd7,  0,1,0, 16'd13);
    step(OP_STR,  16'd0,  0,0,0,0,0, 1, 16'd7,  0,1,0, 16'd13);
    step(OP_STR,  16'd0,  0,0,1,0,0, 1, 16'd7,  1,1,0, 16'd13);  // ack on 3rd wait cycle
    step(OP_ADD,  16'd0,  0,0,1,1,0, 1, 16'd8,  1,0,0, 16'd14);  // stray start/ack ignored
    step(OP_JMP,  16'd30, 0,0,0,0,0, 1, 16'd9,  1,0,0, 16'd15);
    step(OP_HALT, 16'd0,  0,0,0,0,0, 1, 16'd30, 1,0,0, 16'd16);
    step(OP_ADD,  16'd0,  0,0,0,0,0, 1, 16'd30, 0,0,1, 16'd17);
    step(OP_ADD,  16'd0,  0,0,0,0,0, 1, 16'd30, 0,0,1, 16'd17);
    step(OP_ADD,  16'd0,  0,0,0,1,0, 1, 16'd30, 0,0,1, 16'd17);  // restart from HALTED
    step(OP_JMP,  16'hFFFF,0,0,0,0,0,1, 16'd0,  1,0,0, 16'd0);
    step(OP_ADD,  16'd0,  0,0,0,0,0, 1, 16'hFFFF,1,0,0, 16'd1);
    step(OP_BNE,  16'd20, 0,0,0,0,0, 1, 16'd0,  1,0,0, 16'd2);   // wrapped, BNE taken
    step(OP_BEQ,  16'd40, 1,0,0,0,0, 1, 16'd20, 1,0,0, 16'd3);   // BEQ taken
    step(OP_BNE,  16'd99, 1,0,0,0,0, 1, 16'd40, 1,0,0, 16'd4);   // BNE not taken
    step(OP_BLT,  16'd99, 1,0,0,0,0, 1, 16'd41, 1,0,0, 16'd5);   // BLT not taken
    step(OP_TBA,  16'd99, 0,0,0,0,0, 1, 16'd42, 1,0,0, 16'd6);
    step(OP_LB,   16'd0,  0,0,0,0,0, 1, 16'd43, 0,1,0, 16'd7);
    step(OP_LB,   16'd0,  0,0,1,0,1, 1, 16'd43, 0,1,0, 16'd7);   // reset wins over ack
    step(OP_ADD,  16'd0,  0,0,0,0,0, 1, 16'd0,  0,0,0, 16'd0);
    step(OP_ADD,  16'd0,  0,0,0,1,0, 1, 16'd0,  0,0,0, 16'd0);
    for (int i = 0; i < 65540; i++)
      step(OP_ADD, 16'd0, 0,0,0,0,0, 0, 16'd0, 0,0,0, 16'd0);
    step(OP_ADD,  16'd0,  0,0,0,0,0, 1, 16'd4,  1,0,0, 16'hFFFF);
    step(OP_ADD,  16'd0,  0,0,0,0,0, 1, 16'd5,  1,0,0, 16'hFFFF);

    @(negedge clk);
    #3;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
